// File: rtl/can_pkg.sv
// Shared CAN definitions: field widths, scheduler states and default timing constants.
package can_pkg;

    localparam int unsigned CAN_ID_W          = 11;
    localparam int unsigned CAN_DATA_W        = 8;
    localparam int unsigned GRANT_W           = 3;
    localparam int unsigned DEF_RETRY_MAX     = 8;
    localparam int unsigned DEF_START_TIMEOUT = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_LAUNCH,
        ST_WAIT_START,
        ST_WAIT_DONE,
        ST_COMPLETE,
        ST_FAIL
    } sched_state_t;

    typedef struct packed {
        logic [CAN_ID_W-1:0]   id;
        logic [CAN_DATA_W-1:0] data;
    } can_frame_t;

endpackage

// File: rtl/can_prio_sel.sv
// Combinational selector: requesting entry with the lowest CAN ID wins, ties to the lowest index.
module can_prio_sel
    import can_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 3
) (
    input  logic [N-1:0]          req,
    input  logic [N*CAN_ID_W-1:0] addr,
    output logic [IDX_W-1:0]      idx,
    output logic                  valid
);

    logic [CAN_ID_W-1:0] best;
    logic [CAN_ID_W-1:0] cur;

    // Strict less-than keeps the earlier (lower) index on equal IDs.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        best  = '0;
        cur   = '0;
        for (int i = 0; i < int'(N); i++) begin
            cur = addr[i*CAN_ID_W +: CAN_ID_W];
            if (req[i] && (!valid || (cur < best))) begin
                valid = 1'b1;
                best  = cur;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/can_tx_sched.sv
// Transmit scheduler sharing one can_tx between mailboxes: lowest-ID arbitration,
// launch, completion tracking and bounded retry on arbitration loss or start timeout.
module can_tx_sched
    import can_pkg::*;
#(
    parameter int unsigned NUM_MB        = 4,
    parameter int unsigned RETRY_MAX     = DEF_RETRY_MAX,
    parameter int unsigned START_TIMEOUT = DEF_START_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_MB-1:0]          mb_req,
    input  logic [NUM_MB*CAN_ID_W-1:0] mb_addr,
    input  logic [NUM_MB*CAN_DATA_W-1:0] mb_data,
    output logic [NUM_MB-1:0]          mb_ack,
    output logic [NUM_MB-1:0]          mb_err,
    output logic [CAN_ID_W-1:0]        tx_address,
    output logic [CAN_DATA_W-1:0]      tx_data,
    output logic                       send_data,
    input  logic                       clear_to_tx,
    input  logic                       txing,
    input  logic                       arb_lost,
    output logic                       busy,
    output logic [GRANT_W-1:0]         grant_idx
);

    localparam int unsigned RETRY_W = $clog2(RETRY_MAX + 1);
    localparam int unsigned TMO_W   = $clog2(START_TIMEOUT + 1);

    sched_state_t        state, state_next;
    can_frame_t          frame, frame_next;
    logic [GRANT_W-1:0]  grant_next;
    logic                send_next;
    logic                busy_next;
    logic [NUM_MB-1:0]   ack_next, err_next;
    logic [TMO_W-1:0]    tmo_cnt, tmo_next;
    logic [RETRY_W-1:0]  retry_cnt  [NUM_MB];
    logic [RETRY_W-1:0]  retry_next [NUM_MB];
    logic                txing_q;
    logic [GRANT_W-1:0]  sel_idx;
    logic                sel_valid;

    can_prio_sel #(
        .N     (NUM_MB),
        .IDX_W (GRANT_W)
    ) u_sel (
        .req   (mb_req),
        .addr  (mb_addr),
        .idx   (sel_idx),
        .valid (sel_valid)
    );

    assign tx_address = frame.id;
    assign tx_data    = frame.data;

    // Next-state and next-output logic; every registered output is computed here.
    always_comb begin
        state_next = state;
        frame_next = frame;
        grant_next = grant_idx;
        send_next  = 1'b0;
        ack_next   = '0;
        err_next   = '0;
        tmo_next   = tmo_cnt;
        retry_next = retry_cnt;

        case (state)
            ST_IDLE: begin
                if ((|mb_req) && clear_to_tx) begin
                    state_next = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (sel_valid) begin
                    grant_next      = sel_idx;
                    frame_next.id   = mb_addr[sel_idx*CAN_ID_W +: CAN_ID_W];
                    frame_next.data = mb_data[sel_idx*CAN_DATA_W +: CAN_DATA_W];
                    state_next      = ST_LAUNCH;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                send_next  = 1'b1;
                tmo_next   = '0;
                state_next = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (txing) begin
                    state_next = ST_WAIT_DONE;
                end else if (tmo_cnt == TMO_W'(START_TIMEOUT - 1)) begin
                    state_next = ST_FAIL;
                end else begin
                    tmo_next = tmo_cnt + TMO_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                // Arbitration loss takes priority over a coincident end of frame.
                if (arb_lost) begin
                    state_next = ST_FAIL;
                end else if (txing_q && !txing) begin
                    state_next = ST_COMPLETE;
                end
            end
            ST_COMPLETE: begin
                for (int i = 0; i < int'(NUM_MB); i++) begin
                    if (grant_idx == GRANT_W'(i)) begin
                        ack_next[i]   = 1'b1;
                        retry_next[i] = '0;
                    end
                end
                state_next = ST_IDLE;
            end
            ST_FAIL: begin
                for (int i = 0; i < int'(NUM_MB); i++) begin
                    if (grant_idx == GRANT_W'(i)) begin
                        if (retry_cnt[i] == RETRY_W'(RETRY_MAX - 1)) begin
                            err_next[i]   = 1'b1;
                            retry_next[i] = '0;
                        end else begin
                            retry_next[i] = retry_cnt[i] + RETRY_W'(1);
                        end
                    end
                end
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        busy_next = (state_next != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            frame     <= '0;
            grant_idx <= '0;
            send_data <= 1'b0;
            busy      <= 1'b0;
            mb_ack    <= '0;
            mb_err    <= '0;
            tmo_cnt   <= '0;
            txing_q   <= 1'b0;
            for (int i = 0; i < int'(NUM_MB); i++) begin
                retry_cnt[i] <= '0;
            end
        end else begin
            state     <= state_next;
            frame     <= frame_next;
            grant_idx <= grant_next;
            send_data <= send_next;
            busy      <= busy_next;
            mb_ack    <= ack_next;
            mb_err    <= err_next;
            tmo_cnt   <= tmo_next;
            txing_q   <= txing;
            retry_cnt <= retry_next;
        end
    end

endmodule

// File: tb/tb_can_tx_sched.sv
// Bench for can_tx_sched: cycle-stepped requester and can_tx models with a queue-based expectation model.
module tb_can_tx_sched;

    localparam int NMB   = 4;
    localparam int RMAX  = 8;
    localparam int TMO   = 16;
    localparam int TXLEN = 40;
    localparam int LOSE_AT = 2;

    logic              clk;
    logic              rst;
    logic [NMB-1:0]    mb_req;
    logic [NMB*11-1:0] mb_addr;
    logic [NMB*8-1:0]  mb_data;
    logic [NMB-1:0]    mb_ack, mb_err;
    logic [10:0]       tx_address;
    logic [7:0]        tx_data;
    logic              send_data;
    logic              clear_to_tx, txing, arb_lost;
    logic              busy;
    logic [2:0]        grant_idx;

    can_tx_sched #(.NUM_MB(NMB), .RETRY_MAX(RMAX), .START_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .mb_req(mb_req), .mb_addr(mb_addr), .mb_data(mb_data),
        .mb_ack(mb_ack), .mb_err(mb_err), .tx_address(tx_address), .tx_data(tx_data),
        .send_data(send_data), .clear_to_tx(clear_to_tx), .txing(txing),
        .arb_lost(arb_lost), .busy(busy), .grant_idx(grant_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int t; int idx; logic [10:0] addr; logic [7:0] data; } sd_t;
    typedef struct { int t; int idx; bit err; } done_t;

    sd_t   sd_q[$];
    done_t done_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    viol = 0;
    int    tx_t = -1;
    bit    lose_now = 0;
    bit    same_cycle = 0;
    bit    no_start = 0;
    logic [NMB-1:0] lose_mask = '0;

    // One clock: sample just after the edge, then update requester and can_tx models.
    task automatic cycle();
        bit started;
        int len;
        @(posedge clk);
        #1;
        cyc++;
        started = 0;
        if (send_data === 1'b1) begin
            sd_q.push_back('{t: cyc, idx: int'(grant_idx), addr: tx_address, data: tx_data});
            if (!no_start) begin
                tx_t = 0;
                started = 1;
                lose_now = lose_mask[grant_idx[1:0]];
            end
        end
        for (int i = 0; i < NMB; i++) begin
            if (mb_ack[i] === 1'b1) done_q.push_back('{t: cyc, idx: i, err: 0});
            if (mb_err[i] === 1'b1) done_q.push_back('{t: cyc, idx: i, err: 1});
        end
        if (((|mb_ack) && (|mb_err)) || $countones(mb_ack) > 1 || $countones(mb_err) > 1) viol++;
        for (int i = 0; i < NMB; i++) begin
            if (mb_ack[i] === 1'b1 || mb_err[i] === 1'b1) mb_req[i] = 1'b0;
        end
        if (tx_t >= 0 && !started) tx_t++;
        if (tx_t < 0) begin
            txing = 1'b0;
            arb_lost = 1'b0;
        end else begin
            len = lose_now ? (same_cycle ? LOSE_AT : LOSE_AT + 1) : TXLEN;
            txing = (tx_t >= 3 && tx_t < 3 + len);
            arb_lost = lose_now && (tx_t == 3 + LOSE_AT);
            if (tx_t >= 3 + len && !(lose_now && tx_t <= 3 + LOSE_AT)) tx_t = -1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        mb_req = '0;
        tx_t = -1;
        txing = 1'b0;
        arb_lost = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        tx_t = -1;
        txing = 1'b0;
        arb_lost = 1'b0;
        lose_mask = '0;
        same_cycle = 0;
        no_start = 0;
        sd_q.delete();
        done_q.delete();
        viol = 0;
    endtask

    task automatic set_mb(input int i, input logic [10:0] id, input logic [7:0] d);
        mb_addr[i*11 +: 11] = id;
        mb_data[i*8 +: 8] = d;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (!(mb_req == '0 && tx_t < 0 && busy === 1'b0) && n < budget);
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s timeout: still busy after %0d cycles (busy=%b req=%b)", name, n, busy, mb_req);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        mb_req = '0;
        clear_to_tx = 1'b0;
        txing = 1'b0;
        arb_lost = 1'b0;
        mb_addr = '0;
        mb_data = '0;
        cycle();
        cycle();
        checks++;
        if ({mb_ack, mb_err, tx_address, tx_data, send_data, busy, grant_idx} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got ack=%b err=%b addr=%h data=%h sd=%b busy=%b g=%0d exp all 0",
                     mb_ack, mb_err, tx_address, tx_data, send_data, busy, grant_idx);
        end
        rst = 1'b1;
        cycle();
        checks++;
        if (busy !== 1'b0 || send_data !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got busy=%b sd=%b exp 0 0", busy, send_data);
        end
    endtask

    task automatic test_single();
        int t0;
        do_reset();
        clear_to_tx = 1'b1;
        set_mb(1, 11'h123, 8'hA5);
        mb_req[1] = 1'b1;
        t0 = cyc;
        drain("single", 300);
        checks++;
        if (sd_q.size() != 1) begin
            errors++;
            $display("FAIL single_pulses got %0d exp 1", sd_q.size());
        end else begin
            checks++;
            if (sd_q[0].t != t0 + 3) begin
                errors++;
                $display("FAIL single_latency got %0d exp %0d", sd_q[0].t - t0, 3);
            end
            checks++;
            if (sd_q[0].addr !== 11'h123 || sd_q[0].data !== 8'hA5 || sd_q[0].idx != 1) begin
                errors++;
                $display("FAIL single_frame got %h/%h/%0d exp 123/a5/1", sd_q[0].addr, sd_q[0].data, sd_q[0].idx);
            end
            checks++;
            if (done_q.size() != 1 || done_q[0].idx != 1 || done_q[0].err || done_q[0].t != sd_q[0].t + 3 + TXLEN + 2) begin
                errors++;
                $display("FAIL single_ack got n=%0d exp one ack on mb1 at +%0d", done_q.size(), 3 + TXLEN + 2);
            end
        end
        checks++;
        if (busy !== 1'b0 || tx_address !== 11'h123) begin
            errors++;
            $display("FAIL single_hold got busy=%b addr=%h exp 0 123", busy, tx_address);
        end
    endtask

    // Mailboxes raised together; expected order is by (ID, index) rank.
    task automatic run_group(input string name, input logic [NMB-1:0] req,
                             input logic [10:0] ids [NMB], input logic [7:0] ds [NMB]);
        int order[$];
        int rank[NMB];
        int n;
        bit bad;
        sd_q.delete();
        done_q.delete();
        viol = 0;
        n = 0;
        for (int i = 0; i < NMB; i++) begin
            set_mb(i, ids[i], ds[i]);
            rank[i] = 0;
            if (req[i]) begin
                n++;
                for (int j = 0; j < NMB; j++)
                    if (req[j] && j != i && (ids[j] < ids[i] || (ids[j] == ids[i] && j < i))) rank[i]++;
            end
        end
        for (int r = 0; r < n; r++)
            for (int i = 0; i < NMB; i++)
                if (req[i] && rank[i] == r) order.push_back(i);
        mb_req = req;
        drain(name, 100 * NMB);
        bad = (sd_q.size() != n) || (done_q.size() != n);
        if (!bad) begin
            for (int k = 0; k < n; k++) begin
                if (sd_q[k].idx != order[k] || sd_q[k].addr !== ids[order[k]] || sd_q[k].data !== ds[order[k]]) bad = 1;
                if (done_q[k].idx != order[k] || done_q[k].err) bad = 1;
            end
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL %s order got sends=%0d dones=%0d first=%0d exp n=%0d first=%0d",
                     name, sd_q.size(), done_q.size(), (sd_q.size() > 0) ? sd_q[0].idx : -1, n, order[0]);
        end
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL %s onehot got %0d bad cycles exp 0", name, viol);
        end
    endtask

    task automatic test_priority();
        logic [10:0] ids [NMB];
        logic [7:0]  ds [NMB];
        do_reset();
        clear_to_tx = 1'b1;
        ids = '{11'h200, 11'h7FF, 11'h050, 11'h7FF};
        ds  = '{8'h10, 8'h11, 8'h12, 8'h13};
        run_group("priority", 4'b0101, ids, ds);
        ids = '{11'h7FF, 11'h100, 11'h7FF, 11'h100};
        ds  = '{8'h20, 8'h21, 8'h22, 8'h23};
        run_group("tie", 4'b1010, ids, ds);
    endtask

    task automatic test_random();
        logic [10:0] ids [NMB];
        logic [7:0]  ds [NMB];
        logic [NMB-1:0] req;
        bit narrow;
        for (int it = 0; it < 8; it++) begin
            narrow = ($urandom_range(0, 1) == 1);
            for (int i = 0; i < NMB; i++) begin
                ids[i] = narrow ? 11'($urandom_range(0, 3)) : 11'($urandom_range(0, 2047));
                ds[i]  = 8'($urandom_range(0, 255));
            end
            req = NMB'($urandom_range(1, (1 << NMB) - 1));
            run_group("random", req, ids, ds);
        end
    endtask

    task automatic test_retry();
        int losses = 0;
        int n = 0;
        int exp_idx[9] = '{0, 0, 0, 2, 0, 0, 0, 0, 0};
        bit bad = 0;
        do_reset();
        clear_to_tx = 1'b1;
        lose_mask = 4'b0001;
        set_mb(0, 11'h300, 8'h55);
        set_mb(2, 11'h010, 8'h66);
        mb_req[0] = 1'b1;
        while (!(mb_req == '0 && tx_t < 0 && busy === 1'b0) && n < 1000) begin
            cycle();
            n++;
            if (arb_lost) begin
                losses++;
                if (losses == 3) mb_req[2] = 1'b1;
            end
        end
        checks++;
        if (n >= 1000) begin
            errors++;
            $display("FAIL retry timeout got %0d cycles exp idle", n);
        end
        checks++;
        if (sd_q.size() != 9) begin
            errors++;
            $display("FAIL retry_pulses got %0d exp 9", sd_q.size());
        end else begin
            for (int k = 0; k < 9; k++) if (sd_q[k].idx != exp_idx[k]) bad = 1;
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL retry_sequence got idx4=%0d exp 2 before attempt 4", sd_q[3].idx);
            end
        end
        checks++;
        if (done_q.size() != 2 || done_q[0].idx != 2 || done_q[0].err || done_q[1].idx != 0 || !done_q[1].err) begin
            errors++;
            $display("FAIL retry_done got n=%0d exp ack2 then err0", done_q.size());
        end
        checks++;
        if (dut.retry_cnt[0] !== '0) begin
            errors++;
            $display("FAIL retry_cnt0 got %0d exp 0", dut.retry_cnt[0]);
        end
    endtask

    task automatic test_timeout();
        int busy_seen = 0;
        int n = 0;
        do_reset();
        clear_to_tx = 1'b0;
        no_start = 1;
        set_mb(0, 11'h0AA, 8'h77);
        mb_req[0] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (busy !== 1'b0) busy_seen++;
        end
        checks++;
        if (busy_seen != 0 || sd_q.size() != 0) begin
            errors++;
            $display("FAIL blocked got busy_cycles=%0d sends=%0d exp 0 0", busy_seen, sd_q.size());
        end
        clear_to_tx = 1'b1;
        while (sd_q.size() < 2 && n < 200) begin
            cycle();
            n++;
        end
        checks++;
        if (sd_q.size() < 2) begin
            errors++;
            $display("FAIL timeout_retry got %0d sends exp 2", sd_q.size());
        end else begin
            checks++;
            if (sd_q[1].t - sd_q[0].t != TMO + 4 || done_q.size() != 0) begin
                errors++;
                $display("FAIL timeout_gap got %0d exp %0d (dones=%0d)", sd_q[1].t - sd_q[0].t, TMO + 4, done_q.size());
            end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        bit bad = 0;
        do_reset();
        clear_to_tx = 1'b1;
        set_mb(1, 11'h321, 8'h99);
        mb_req[1] = 1'b1;
        while (tx_t != 10 && n < 100) begin
            cycle();
            n++;
        end
        rst = 1'b0;
        mb_req = '0;
        cycle();
        checks++;
        if ({mb_ack, mb_err, tx_address, tx_data, send_data, busy, grant_idx} !== '0 || n >= 100) begin
            errors++;
            $display("FAIL midreset_outputs got addr=%h busy=%b g=%0d exp all 0", tx_address, busy, grant_idx);
        end
        rst = 1'b1;
        tx_t = -1;
        txing = 1'b0;
        for (int i = 0; i < 60; i++) cycle();
        for (int i = 0; i < NMB; i++) if (dut.retry_cnt[i] !== '0) bad = 1;
        checks++;
        if (done_q.size() != 0 || sd_q.size() != 1 || bad || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_after got dones=%0d sends=%0d cnt_bad=%0d busy=%b exp 0 1 0 0",
                     done_q.size(), sd_q.size(), bad, busy);
        end
        do_reset();
        clear_to_tx = 1'b1;
        lose_mask = 4'b0010;
        same_cycle = 1;
        mb_req[1] = 1'b1;
        drain("samecycle", 1000);
        checks++;
        if (sd_q.size() != RMAX || done_q.size() != 1 || !done_q[0].err || done_q[0].idx != 1) begin
            errors++;
            $display("FAIL samecycle got sends=%0d dones=%0d exp %0d sends and one err on mb1",
                     sd_q.size(), done_q.size(), RMAX);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_random();
        test_retry();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
